regfile_bypass: RTL and testbench
=================================

# regfile_bypass

Parametrised successor to the pipeline's integer register file. It adds N combinational read ports, write-to-read bypass in the same cycle, synchronous clearing, and a pending-write scoreboard. The block sits between decode (ID) and writeback (WB) of the 5-stage RV32I pipeline. ID reads operands and marks destinations pending; WB writes results and clears pending state. `rd_busy` feeds the hazard/stall unit directly.

## Interface
- `XLEN`, default 32: register width in bits.
- `NREG`, default 32: number of architectural registers; power of two, ≥ 2.
- `NRD`, default 2: number of read ports, 1..4.
- `AW`, default $clog2(NREG): address width; derived, never overridden.

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: synchronous, active-low reset.
- `rd_addr`  in  NRD*AW: packed read addresses; port i occupies [i*AW +: AW].
- `rd_data`  out  NRD*XLEN: packed read data; port i occupies [i*XLEN +: XLEN].
- `rd_busy`  out  NRD: port i's operand has an outstanding, un-bypassed producer.
- `w_en`  in  1: write enable (WB).
- `w_addr`  in  AW: write address.
- `w_data`  in  XLEN: write data.
- `iss_en`  in  1: issue; marks `iss_addr` pending (ID).
- `iss_addr`  in  AW: destination register being issued.
- `busy_vec`  out  NREG: registered pending bits, for debug and flush logic.

## Operation
- **Register 0**
  - Hardwired zero.
  - Writes to address 0 are discarded; issues to address 0 are discarded.
  - `rd_data` = 0 and `rd_busy` = 0 on any port addressing 0.
- **Write:** at a rising edge with `rst_n`=1, `w_en`=1 and `w_addr`≠0, `regs[w_addr]` ← `w_data`.
- **Bypass**
  - Read ports are combinational.
  - If `w_en`=1, `w_addr`=`rd_addr[i]` and `w_addr`≠0, then `rd_data[i]` = `w_data` in the same cycle. Otherwise `rd_data[i]` = `regs[rd_addr[i]]`.
- **Scoreboard, per register r≠0, at each edge**
  - issue only → `busy[r]` ← 1.
  - write only → `busy[r]` ← 0.
  - issue and write to the same r in the same cycle → `busy[r]` ← 1; the new producer wins.
  - neither → `busy[r]` holds.
- **Busy output:** `rd_busy[i]` = `busy[a]` & ~(`w_en` & `w_addr`==a), where a = `rd_addr[i]`. A register being written this cycle is never reported busy to a reader.
- A write to a register that is not busy is legal: data is updated and `busy` stays 0.
- Duplicate read addresses across ports return identical data and busy values.
- **Reset**
  - `rst_n`=0 at an edge sets all `regs` to 0 and all `busy` to 0.
  - Reset dominates any concurrent write or issue.
  - Reset asserted mid-sequence drops all pending bits; no write survives.

## Timing
- Read path: 0-cycle latency (combinational from `rd_addr`, `regs`, `busy`, `w_*`).
- Write path: 0-cycle to readers via bypass; registered state is visible from the next cycle.
- Issue: `busy` is visible on `busy_vec` and `rd_busy` from the cycle after `iss_en`.
- Output values after reset:
  - `busy_vec` = 0.
  - `rd_busy` = 0, given `w_en`=0.
  - `rd_data` = 0 for every address, given `w_en`=0.
- No handshakes.
  - ID must not issue when its own `rd_busy` is 1; the stall unit enforces this.
  - The block does not check for multiple outstanding producers of one register.

## Structure
- Shared package `rv32i_pkg` carries:
  - `XLEN`, `NREG`, `REG_ZERO` (5'd0);
  - a typedef `reg_addr_t`, [4:0];
  - a typedef `word_t`, [XLEN-1:0].
- Sub-module `regfile_scoreboard`
  - Holds the NREG-bit busy vector with the set/clear priority above.
  - Ports: `clk`, `rst_n`, `iss_en`/`iss_addr`, `w_en`/`w_addr`, `busy_vec`.
- Top level holds the data array, the per-port bypass muxes, and the `rd_busy` masking.

## Test plan
- **Reset, then write x1:** reset, then write x1=0000AAAA → next cycle `rd_addr`[0]=1 gives 0000AAAA, `rd_busy`[0]=0.
- **Same-cycle bypass:** `w_en`=1, `w_addr`=2, `w_data`=00005555, `rd_addr`[1]=2 in the same cycle → `rd_data`[1]=00005555 combinationally, before the edge.
- **x0 is untouchable:** write x0=FFFFFFFF and issue x0 → read x0 gives 00000000; `busy_vec`[0]=0.
- **Scoreboard lifecycle:**
  - issue x5 → next cycle `busy_vec`[5]=1, and reading x5 gives `rd_busy`=1;
  - the cycle WB writes x5=12345678 → `rd_busy`=0, `rd_data`=12345678;
  - the cycle after → `busy_vec`[5]=0.
- **Simultaneous issue and write to x7 → `busy_vec`[7]=1** the next cycle, and `regs`[7] holds the written data.
- **Reset mid-operation:** issue x3 and x4, write x3=DEADBEEF, then `rst_n`=0 for one edge → all `rd_data`=0 and `busy_vec`=0; NRD=4 variant: four ports reading 1, 2, 2, 0 return the correct, consistent values.

Source files
------------

// File: rtl/rv32i_pkg.sv
// rtl/rv32i_pkg.sv - shared RV32I pipeline constants and register-file types
package rv32i_pkg;
  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef logic [4:0]      reg_addr_t;
  typedef logic [XLEN-1:0] word_t;
endpackage

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - pending-write bits; ID issue sets, WB write clears
module regfile_scoreboard #(
  parameter int NREG = rv32i_pkg::NREG,
  parameter int AW   = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            iss_en,
  input  logic [AW-1:0]   iss_addr,
  input  logic            w_en,
  input  logic [AW-1:0]   w_addr,
  output logic [NREG-1:0] busy_vec
);
  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;

  // Clear first, then set, so a same-cycle issue (the new producer) wins.
  always_comb begin
    busy_d = busy_q;
    if (w_en && (w_addr != '0)) busy_d[w_addr] = 1'b0;
    if (iss_en && (iss_addr != '0)) busy_d[iss_addr] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  assign busy_vec = busy_q;
endmodule

// File: rtl/regfile_bypass.sv
// rtl/regfile_bypass.sv - multi-port integer register file with WB->ID bypass
// and a pending-write scoreboard feeding the stall unit.
module regfile_bypass #(
  parameter int XLEN = rv32i_pkg::XLEN,
  parameter int NREG = rv32i_pkg::NREG,
  parameter int NRD  = 2,
  parameter int AW   = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NRD*AW-1:0] rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]    rd_busy,
  input  logic              w_en,
  input  logic [AW-1:0]     w_addr,
  input  logic [XLEN-1:0]   w_data,
  input  logic              iss_en,
  input  logic [AW-1:0]     iss_addr,
  output logic [NREG-1:0]   busy_vec
);
  logic [XLEN-1:0] regs_q [NREG];

  regfile_scoreboard #(.NREG(NREG), .AW(AW)) u_sb (
    .clk      (clk),
    .rst_n    (rst_n),
    .iss_en   (iss_en),
    .iss_addr (iss_addr),
    .w_en     (w_en),
    .w_addr   (w_addr),
    .busy_vec (busy_vec)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int r = 0; r < NREG; r++) regs_q[r] <= '0;
    end else if (w_en && (w_addr != '0)) begin
      regs_q[w_addr] <= w_data;
    end
  end

  // x0 is forced to zero on the read side so its storage is never consulted.
  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int i = 0; i < NRD; i++) begin
      logic [AW-1:0] a;
      logic          hit;
      a   = rd_addr[i*AW +: AW];
      hit = w_en && (w_addr == a);
      if (a != '0) begin
        rd_data[i*XLEN +: XLEN] = hit ? w_data : regs_q[a];
        rd_busy[i]              = busy_vec[a] & ~hit;
      end
    end
  end
endmodule

// File: tb/tb_regfile_bypass.sv
// tb/tb_regfile_bypass.sv - directed vector bench for regfile_bypass (NRD=4)
module tb_regfile_bypass;
  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int NRD  = 4;
  localparam int AW   = 5;

  logic              clk;
  logic              rst_n;
  logic [NRD*AW-1:0] rd_addr;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0]    rd_busy;
  logic              w_en;
  logic [AW-1:0]     w_addr;
  logic [XLEN-1:0]   w_data;
  logic              iss_en;
  logic [AW-1:0]     iss_addr;
  logic [NREG-1:0]   busy_vec;

  int tests;
  int fails;

  regfile_bypass #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_busy  (rd_busy),
    .w_en     (w_en),
    .w_addr   (w_addr),
    .w_data   (w_data),
    .iss_en   (iss_en),
    .iss_addr (iss_addr),
    .busy_vec (busy_vec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        ie;
    logic [4:0]  ia;
    logic [19:0] ra;
    logic [127:0] ed;
    logic [3:0]  eb;
    logic [31:0] ebv;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [19:0] ra4(input logic [4:0] a0, a1, a2, a3);
    return {a3, a2, a1, a0};
  endfunction

  function automatic logic [127:0] ed4(input logic [31:0] d0, d1, d2, d3);
    return {d3, d2, d1, d0};
  endfunction

  task automatic add(input string n, input logic we, input logic [4:0] wa,
                     input logic [31:0] wd, input logic ie, input logic [4:0] ia,
                     input logic [19:0] ra, input logic [127:0] ed,
                     input logic [3:0] eb, input logic [31:0] ebv);
    vec_t v;
    v.name = n; v.we = we; v.wa = wa; v.wd = wd; v.ie = ie; v.ia = ia;
    v.ra = ra; v.ed = ed; v.eb = eb; v.ebv = ebv;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic rst, input logic we, input logic [4:0] wa,
                       input logic [31:0] wd, input logic ie, input logic [4:0] ia,
                       input logic [19:0] ra);
    @(negedge clk);
    rst_n = rst; w_en = we; w_addr = wa; w_data = wd;
    iss_en = ie; iss_addr = ia; rd_addr = ra;
    #2;
  endtask

  task automatic chk(input string n, input logic [127:0] ed,
                     input logic [3:0] eb, input logic [31:0] ebv);
    tests++;
    if (rd_data !== ed) begin
      fails++;
      $display("FAIL %s rd_data got %h expected %h", n, rd_data, ed);
    end
    tests++;
    if (rd_busy !== eb) begin
      fails++;
      $display("FAIL %s rd_busy got %b expected %b", n, rd_busy, eb);
    end
    tests++;
    if (busy_vec !== ebv) begin
      fails++;
      $display("FAIL %s busy_vec got %h expected %h", n, busy_vec, ebv);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0; w_en = 1'b0; w_addr = '0; w_data = '0;
    iss_en = 1'b0; iss_addr = '0; rd_addr = '0;

    add("reset_state", 0, 0, 0, 0, 0, ra4(1, 2, 3, 0), ed4(0, 0, 0, 0), 4'b0000, 32'h0);
    add("wr_x1_bypass", 1, 1, 32'h0000AAAA, 0, 0, ra4(1, 0, 0, 0), ed4(32'h0000AAAA, 0, 0, 0), 4'b0000, 32'h0);
    add("rd_x1_reg", 0, 0, 0, 0, 0, ra4(1, 1, 0, 0), ed4(32'h0000AAAA, 32'h0000AAAA, 0, 0), 4'b0000, 32'h0);
    add("bypass_p1_x2", 1, 2, 32'h00005555, 0, 0, ra4(0, 2, 0, 0), ed4(0, 32'h00005555, 0, 0), 4'b0000, 32'h0);
    add("x0_write_issue", 1, 0, 32'hFFFFFFFF, 1, 0, ra4(0, 1, 2, 0), ed4(0, 32'h0000AAAA, 32'h00005555, 0), 4'b0000, 32'h0);
    add("x0_after", 0, 0, 0, 0, 0, ra4(0, 0, 0, 0), ed4(0, 0, 0, 0), 4'b0000, 32'h0);
    add("issue_x5", 0, 0, 0, 1, 5, ra4(5, 0, 0, 0), ed4(0, 0, 0, 0), 4'b0000, 32'h0);
    add("x5_busy", 0, 0, 0, 0, 0, ra4(5, 5, 0, 0), ed4(0, 0, 0, 0), 4'b0011, 32'h0000_0020);
    add("wb_x5", 1, 5, 32'h12345678, 0, 0, ra4(5, 0, 0, 0), ed4(32'h12345678, 0, 0, 0), 4'b0000, 32'h0000_0020);
    add("x5_cleared", 0, 0, 0, 0, 0, ra4(5, 0, 0, 0), ed4(32'h12345678, 0, 0, 0), 4'b0000, 32'h0);
    add("iss_wr_x7", 1, 7, 32'hCAFEF00D, 1, 7, ra4(7, 0, 0, 0), ed4(32'hCAFEF00D, 0, 0, 0), 4'b0000, 32'h0);
    add("x7_still_busy", 0, 0, 0, 0, 0, ra4(7, 0, 0, 0), ed4(32'hCAFEF00D, 0, 0, 0), 4'b0001, 32'h0000_0080);
    add("wb_x7", 1, 7, 32'h11111111, 0, 0, ra4(7, 7, 0, 0), ed4(32'h11111111, 32'h11111111, 0, 0), 4'b0000, 32'h0000_0080);
    add("x7_cleared", 0, 0, 0, 0, 0, ra4(7, 1, 2, 5), ed4(32'h11111111, 32'h0000AAAA, 32'h00005555, 32'h12345678), 4'b0000, 32'h0);

    drive(0, 0, 0, 0, 0, 0, '0);
    drive(0, 0, 0, 0, 0, 0, '0);

    foreach (vecs[k]) begin
      drive(1, vecs[k].we, vecs[k].wa, vecs[k].wd, vecs[k].ie, vecs[k].ia, vecs[k].ra);
      chk(vecs[k].name, vecs[k].ed, vecs[k].eb, vecs[k].ebv);
    end

    // Reset mid-operation: pending bits and stored data must all vanish,
    // and a write/issue coinciding with reset must not survive.
    drive(1, 0, 0, 0, 1, 3, ra4(3, 0, 0, 0));
    chk("iss_x3", ed4(0, 0, 0, 0), 4'b0000, 32'h0);
    drive(1, 0, 0, 0, 1, 4, ra4(3, 4, 0, 0));
    chk("iss_x4", ed4(0, 0, 0, 0), 4'b0001, 32'h0000_0008);
    drive(1, 1, 3, 32'hDEADBEEF, 0, 0, ra4(3, 4, 0, 0));
    chk("wb_x3", ed4(32'hDEADBEEF, 0, 0, 0), 4'b0010, 32'h0000_0018);
    drive(0, 1, 2, 32'h00000099, 1, 6, ra4(3, 4, 0, 0));
    chk("pre_reset", ed4(32'hDEADBEEF, 0, 0, 0), 4'b0010, 32'h0000_0010);
    drive(1, 0, 0, 0, 0, 0, ra4(1, 2, 2, 0));
    chk("post_reset_a", ed4(0, 0, 0, 0), 4'b0000, 32'h0);
    drive(1, 0, 0, 0, 0, 0, ra4(3, 4, 5, 7));
    chk("post_reset_b", ed4(0, 0, 0, 0), 4'b0000, 32'h0);

    drive(1, 1, 1, 32'h00000001, 0, 0, ra4(0, 0, 0, 0));
    drive(1, 1, 2, 32'h00000002, 1, 2, ra4(1, 2, 2, 0));
    chk("dup_bypass", ed4(1, 2, 2, 0), 4'b0000, 32'h0);
    drive(1, 0, 0, 0, 0, 0, ra4(1, 2, 2, 0));
    chk("dup_busy", ed4(1, 2, 2, 0), 4'b0110, 32'h0000_0004);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
